// File: rtl/mdu_unit.sv
// Multiply/divide unit: HI/LO commit after MULT_CYCLES or DIV_CYCLES busy cycles following Start.
// While Busy is high, new mult/div and mthi/mtlo ops are ignored; upstream stalls on Start|Busy.
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDUOpE,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   input  logic        FlushE,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] MDUOutE,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic [3:0]    op_q;
   logic [31:0]   a_q;
   logic [31:0]   b_q;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        signed_div;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] divisor;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] quo;
   logic [31:0] rem;

   assign Busy  = (state == ST_RUN);
   assign Start = !FlushE && (state == ST_IDLE) && (MDUOpE != 4'd0) && (MDUOpE <= 4'd4);

   always_comb begin
      MDUOutE = 32'd0;
      if (MDUOpE == OP_MFHI)
         MDUOutE = HI;
      else if (MDUOpE == OP_MFLO)
         MDUOutE = LO;
   end

   // Signed divide goes through magnitudes so truncation is toward zero and
   // the remainder takes the dividend's sign; a zero divisor is steered to 1
   // only to keep the divider defined, its result is never committed.
   always_comb begin
      prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u     = {32'd0, a_q} * {32'd0, b_q};
      signed_div = (op_q == OP_DIV);
      mag_a      = (signed_div && a_q[31]) ? -a_q : a_q;
      mag_b      = (signed_div && b_q[31]) ? -b_q : b_q;
      divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
      uq         = mag_a / divisor;
      ur         = mag_a % divisor;
      quo        = (signed_div && (a_q[31] ^ b_q[31])) ? -uq : uq;
      rem        = (signed_div && a_q[31]) ? -ur : ur;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         op_q  <= 4'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         HI    <= 32'd0;
         LO    <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  op_q  <= MDUOpE;
                  a_q   <= SrcA;
                  b_q   <= SrcB;
                  cnt   <= (MDUOpE <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                  state <= ST_RUN;
               end else if (!FlushE && MDUOpE == OP_MTHI) begin
                  HI <= SrcA;
               end else if (!FlushE && MDUOpE == OP_MTLO) begin
                  LO <= SrcA;
               end
            end
            ST_RUN: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= ST_IDLE;
                  if (op_q == OP_MULT) begin
                     HI <= prod_s[63:32];
                     LO <= prod_s[31:0];
                  end else if (op_q == OP_MULTU) begin
                     HI <= prod_u[63:32];
                     LO <= prod_u[31:0];
                  end else if (b_q != 32'd0) begin
                     HI <= rem;
                     LO <= quo;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed vector table plus hand sequences for busy-time hazards, flush and mid-run reset.
module tb_mdu_unit;

   logic        clk;
   logic        reset;
   logic [3:0]  MDUOpE;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        FlushE;
   logic        Start;
   logic        Busy;
   logic [31:0] MDUOutE;
   logic [31:0] HI;
   logic [31:0] LO;

   int tests = 0;
   int fails = 0;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .MDUOpE  (MDUOpE),
      .SrcA    (SrcA),
      .SrcB    (SrcB),
      .FlushE  (FlushE),
      .Start   (Start),
      .Busy    (Busy),
      .MDUOutE (MDUOutE),
      .HI      (HI),
      .LO      (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        start;
      int          cycles;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Counts negedges with Busy high until it drops; -1 if it never drops.
   task automatic wait_idle(output int count);
      bit done;
      done  = 1'b0;
      count = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (!Busy) done = 1'b1;
         else count++;
      end
      if (!done) count = -1;
   endtask

   initial begin
      int n;

      vecs[0]  = '{4'd1,  32'hFFFFFFFE, 32'h3,        1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1]  = '{4'd2,  32'hFFFFFFFE, 32'h3,        1'b1, 5,  32'h00000002, 32'hFFFFFFFA};
      vecs[2]  = '{4'd3,  32'hFFFFFFF9, 32'h2,        1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{4'd7,  32'h00001234, 32'h0,        1'b0, 0,  32'h00001234, 32'hFFFFFFFD};
      vecs[4]  = '{4'd4,  32'h00000005, 32'h0,        1'b1, 10, 32'h00001234, 32'hFFFFFFFD};
      vecs[5]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 1'b1, 10, 32'h00000000, 32'h80000000};
      vecs[6]  = '{4'd4,  32'hFFFFFFF9, 32'h2,        1'b1, 10, 32'h00000001, 32'h7FFFFFFC};
      vecs[7]  = '{4'd8,  32'hCAFEBABE, 32'h0,        1'b0, 0,  32'h00000001, 32'hCAFEBABE};
      vecs[8]  = '{4'd3,  32'h00000007, 32'hFFFFFFFE, 1'b1, 10, 32'h00000001, 32'hFFFFFFFD};
      vecs[9]  = '{4'd1,  32'h80000000, 32'h80000000, 1'b1, 5,  32'h40000000, 32'h00000000};
      vecs[10] = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5,  32'hFFFFFFFE, 32'h00000001};
      vecs[11] = '{4'd9,  32'hDEADBEEF, 32'h1,        1'b0, 0,  32'hFFFFFFFE, 32'h00000001};
      vecs[12] = '{4'd15, 32'h12345678, 32'h1,        1'b0, 0,  32'hFFFFFFFE, 32'h00000001};

      reset  = 1'b0;
      MDUOpE = 4'd0;
      SrcA   = 32'd0;
      SrcB   = 32'd0;
      FlushE = 1'b0;
      #1;
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_start", {31'd0, Start}, 32'd0);
      MDUOpE = 4'd5;
      #1;
      check("rst_mfhi", MDUOutE, 32'd0);
      MDUOpE = 4'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         MDUOpE = vecs[i].op;
         SrcA   = vecs[i].a;
         SrcB   = vecs[i].b;
         #1;
         check($sformatf("vec%0d_start", i), {31'd0, Start}, {31'd0, vecs[i].start});
         @(posedge clk);
         #1;
         MDUOpE = 4'd0;
         wait_idle(n);
         check($sformatf("vec%0d_cycles", i), n, vecs[i].cycles);
         check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
         MDUOpE = 4'd5;
         #1;
         check($sformatf("vec%0d_mfhi", i), MDUOutE, vecs[i].hi);
         MDUOpE = 4'd6;
         #1;
         check($sformatf("vec%0d_mflo", i), MDUOutE, vecs[i].lo);
         MDUOpE = 4'd0;
      end

      // div 100/7 with hazards injected while it runs; HI=FFFFFFFE LO=1 beforehand
      @(negedge clk);
      MDUOpE = 4'd3;
      SrcA   = 32'd100;
      SrcB   = 32'd7;
      #1;
      check("busy_div_start", {31'd0, Start}, 32'd1);
      @(posedge clk);
      #1;
      MDUOpE = 4'd0;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (!Busy) break;
         n++;
         MDUOpE = 4'd0;
         FlushE = 1'b0;
         case (k)
            2: begin
               MDUOpE = 4'd1; SrcA = 32'd5; SrcB = 32'd5;
               #1;
               check("busy_mult_start", {31'd0, Start}, 32'd0);
            end
            3: begin
               MDUOpE = 4'd5;
               #1;
               check("busy_mfhi_old", MDUOutE, 32'hFFFFFFFE);
               check("busy_hi_hold", HI, 32'hFFFFFFFE);
               check("busy_lo_hold", LO, 32'h00000001);
            end
            4: begin MDUOpE = 4'd7; SrcA = 32'h0000DEAD; end
            5: FlushE = 1'b1;
            6: begin MDUOpE = 4'd8; SrcA = 32'h0000BEEF; end
            default: ;
         endcase
      end
      MDUOpE = 4'd0;
      FlushE = 1'b0;
      check("busy_div_cycles", n, 10);
      check("busy_div_hi", HI, 32'h00000002);
      check("busy_div_lo", LO, 32'h0000000E);
      repeat (3) @(negedge clk);
      check("busy_no_restart", {31'd0, Busy}, 32'd0);

      // FlushE cancels an accept and an mthi
      @(negedge clk);
      MDUOpE = 4'd1;
      FlushE = 1'b1;
      #1;
      check("flush_start", {31'd0, Start}, 32'd0);
      @(posedge clk);
      #1;
      MDUOpE = 4'd7;
      SrcA   = 32'h55;
      @(posedge clk);
      #1;
      MDUOpE = 4'd0;
      FlushE = 1'b0;
      @(negedge clk);
      check("flush_busy", {31'd0, Busy}, 32'd0);
      check("flush_hi", HI, 32'h00000002);

      // reset in cycle 3 of a mult discards it
      @(negedge clk);
      MDUOpE = 4'd1;
      SrcA   = 32'd3;
      SrcB   = 32'd4;
      @(posedge clk);
      #1;
      MDUOpE = 4'd0;
      repeat (3) @(negedge clk);
      check("rstmid_busy_before", {31'd0, Busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("rstmid_busy", {31'd0, Busy}, 32'd0);
      check("rstmid_hi", HI, 32'd0);
      check("rstmid_lo", LO, 32'd0);
      @(negedge clk);
      reset  = 1'b1;
      MDUOpE = 4'd8;
      SrcA   = 32'h77;
      @(posedge clk);
      #1;
      MDUOpE = 4'd0;
      @(negedge clk);
      check("rel_first_mtlo", LO, 32'h00000077);
      repeat (8) @(negedge clk);
      check("rstmid_no_commit_hi", HI, 32'd0);
      check("rstmid_no_commit_lo", LO, 32'h00000077);
      check("rstmid_idle", {31'd0, Busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy-cycle count for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy-cycle count for div/divu.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MDUOpE  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none.
REQ-006 SHALL have port SrcA  input  32  rs operand.
REQ-007 SHALL have port SrcB  input  32  rt operand.
REQ-008 SHALL have port FlushE  input  1  E-stage instruction cancelled; suppresses every op that cycle.
REQ-009 SHALL have port Start  output  1  combinational; high when ops 1-4 are accepted this cycle.
REQ-010 SHALL have port Busy  output  1  registered; high while a multiply/divide is in flight.
REQ-011 SHALL have port MDUOutE  output  32  combinational: HI for op 5, LO for op 6, else 0; feeds the E->M register MDUOutE input.
REQ-012 SHALL have ports HI and LO  output  32 each  architectural HI/LO registers.

Function
REQ-013 Accept: ops 1-4 accepted when FlushE=0 and Busy=0; Start = accept.
REQ-014 On accept: SrcA/SrcB and the op SHALL be latched; a down-counter SHALL load MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4); Busy SHALL rise at the next edge.
REQ-015 States: IDLE (Busy=0) -> RUN on accept; RUN decrements the counter each cycle; RUN -> IDLE on the edge where the counter goes 1 -> 0.
REQ-016 Latency: Busy high for exactly N cycles after the Start cycle.
REQ-017 Commit: HI/LO written on the same edge that clears Busy; the new value is visible the cycle Busy is first low.
REQ-018 Arithmetic for mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-019 Arithmetic for div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-020 Arithmetic for divu: unsigned quotient/remainder.
REQ-021 Divide edge case: divisor 0 leaves HI and LO unchanged at commit; Busy timing is unchanged.
REQ-022 Divide edge case: signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-023 While Busy=1, HI/LO SHALL hold their pre-operation values.
REQ-024 While Busy=1, ops 1-4 SHALL be ignored (no restart, Start=0).
REQ-025 While Busy=1, ops 7-8 SHALL be ignored, and ops 5-6 return the old values; upstream hazard logic stalls on Start|Busy.
REQ-026 mthi/mtlo (FlushE=0, Busy=0) SHALL write SrcA into HI/LO at the edge.
REQ-027 Ops 0 and 9-15 SHALL cause no state change.
REQ-028 FlushE during RUN SHALL NOT abort the in-flight operation.
REQ-029 Combinational paths: MDUOutE depends only on MDUOpE, HI and LO (no path from SrcA/SrcB).

Reset
REQ-030 reset low SHALL asynchronously force HI=0, LO=0, Busy=0, counter=0, latched operands/op=0, state IDLE.
REQ-031 Start and MDUOutE SHALL follow combinationally from cleared state.
REQ-032 Reset asserted mid-RUN SHALL discard the operation with no commit.
REQ-033 Release is synchronous-safe: the first accept is possible on the first rising edge after reset goes high.

Verification
REQ-034 mult SrcA=0xFFFFFFFE, SrcB=3 -> Start=1 one cycle; Busy=1 cycles 1-5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 multu same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
REQ-036 div SrcA=-7 (0xFFFFFFF9), SrcB=2 -> 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; mfhi during Busy returns prior HI.
REQ-037 mthi SrcA=0x1234, then divu SrcB=0 -> after 10 cycles HI=0x1234, LO unchanged.
REQ-038 Second mult issued cycle 2 of a running div -> ignored, Start=0; HI/LO reflect only the div.
REQ-039 reset low at cycle 3 of mult -> Busy=0, HI=LO=0 immediately; no later commit.
